deint_pingpong_ctrl: RTL and testbench

- Sequencing controller for the block de-interleaver datapath.
- Owns a two-bank ping-pong buffer held in an external simple-dual-port RAM. Generates row-major write addresses and column-major read addresses, and arbitrates bank ownership between the write and read sides.
- Sits between the upstream AXIS-like word stream and the downstream decoder.
- Adds full output backpressure via a 2-entry output buffer. The RAM has 1-cycle registered read latency.

---
 rtl/deint_pkg.sv | 24 ++
 rtl/deint_out_buf2.sv | 63 ++++++
 rtl/deint_pingpong_ctrl.sv | 175 +++++++++++++++++
 tb/tb_deint_pingpong_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deint_pkg.sv
// Shared types and helpers for the ping-pong de-interleaver controller.
package deint_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    localparam int DEF_ROW_LEN  = 65;
    localparam int DEF_NUM_ROWS = 4;
    localparam int BANK_WORDS   = DEF_ROW_LEN * DEF_NUM_ROWS;

    // Flat RAM address of (bank, row, col) with banks stacked back to back.
    function automatic int unsigned bank_addr(input int unsigned bank,
                                              input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned row_len,
                                              input int unsigned num_rows);
        return bank * num_rows * row_len + row * row_len + col;
    endfunction

endpackage

// File: rtl/deint_out_buf2.sv
// Two-entry output FIFO fed by a RAM with one cycle of read latency.
// can_issue says whether one more read may be launched this cycle.
module deint_out_buf2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         issue,
    input  logic [W-1:0] in_data,
    output logic         can_issue,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         inflight_q, inflight_d;
    logic         push, pop;

    assign m_valid = (count_q != 2'd0);
    assign m_data  = rd_ptr_q ? ent1_q : ent0_q;
    assign pop     = m_valid && m_ready;
    assign push    = inflight_q;

    // Credit the word leaving this cycle so back-to-back reads sustain full rate.
    assign can_issue = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));

    always_comb begin
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = issue;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            if (wr_ptr_q) ent1_d = in_data;
            else          ent0_d = in_data;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: rtl/deint_pingpong_ctrl.sv
// Ping-pong bank sequencer: row-major writes, column-major reads, 2-deep output buffer.
// Optional m_axis_tlast on the final word of each bank when DEINT_TLAST_EN is defined.
module deint_pingpong_ctrl
    import deint_pkg::*;
#(
    parameter  int ROW_LEN  = DEF_ROW_LEN,
    parameter  int NUM_ROWS = DEF_NUM_ROWS,
    parameter  int DATA_W   = 32,
    localparam int ADDR_W   = $clog2(2 * NUM_ROWS * ROW_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
`ifdef DEINT_TLAST_EN
    output logic              m_axis_tlast,
`endif
    output logic [1:0]        bank_full
);

    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LEN - 1);

    bank_state_t      bank_st_q [2];
    bank_state_t      bank_st_d [2];
    logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [ROW_W-1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [COL_W-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
    logic             s_ready_q, s_ready_d;
    logic             wr_fire, wr_last, rd_at_end, can_issue;

    assign wr_fire   = s_axis_tvalid && s_ready_q;
    assign wr_last   = (wr_row_q == LAST_ROW) && (wr_col_q == LAST_COL);
    assign rd_at_end = (rd_row_q == LAST_ROW) && (rd_col_q == LAST_COL);

    // Bank state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st_q[0] <= EMPTY;
            bank_st_q[1] <= EMPTY;
        end else begin
            bank_st_q[0] <= bank_st_d[0];
            bank_st_q[1] <= bank_st_d[1];
        end
    end

    // Bank next state; the writer and reader never own the same bank at once.
    always_comb begin
        bank_st_d[0] = bank_st_q[0];
        bank_st_d[1] = bank_st_q[1];
        if (wr_fire) begin
            if (bank_st_q[wr_bank_q] == EMPTY || bank_st_q[wr_bank_q] == FILLING)
                bank_st_d[wr_bank_q] = wr_last ? FULL : FILLING;
        end
        if (ram_rd_en) begin
            if (bank_st_q[rd_bank_q] == FULL || bank_st_q[rd_bank_q] == DRAINING)
                bank_st_d[rd_bank_q] = rd_at_end ? EMPTY : DRAINING;
        end
    end

    // Outputs decoded from bank state.
    always_comb begin
        bank_full[0] = (bank_st_q[0] == FULL) || (bank_st_q[0] == DRAINING);
        bank_full[1] = (bank_st_q[1] == FULL) || (bank_st_q[1] == DRAINING);
        ram_rd_en    = bank_full[rd_bank_q] && can_issue;
    end

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        rd_bank_d = rd_bank_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        if (wr_fire) begin
            if (wr_col_q == LAST_COL) begin
                wr_col_d = '0;
                wr_row_d = (wr_row_q == LAST_ROW) ? '0 : wr_row_q + 1'b1;
            end else begin
                wr_col_d = wr_col_q + 1'b1;
            end
            if (wr_last) wr_bank_d = ~wr_bank_q;
        end
        // Reads walk down a column first, then step to the next column.
        if (ram_rd_en) begin
            if (rd_row_q == LAST_ROW) begin
                rd_row_d = '0;
                rd_col_d = (rd_col_q == LAST_COL) ? '0 : rd_col_q + 1'b1;
            end else begin
                rd_row_d = rd_row_q + 1'b1;
            end
            if (rd_at_end) rd_bank_d = ~rd_bank_q;
        end
        s_ready_d = (bank_st_d[wr_bank_d] == EMPTY) || (bank_st_d[wr_bank_d] == FILLING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            s_ready_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            rd_bank_q <= rd_bank_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign ram_wr_en     = wr_fire;
    assign ram_wr_data   = s_axis_tdata;
    assign ram_wr_addr   = ADDR_W'(bank_addr(32'(wr_bank_q), 32'(wr_row_q), 32'(wr_col_q),
                                             ROW_LEN, NUM_ROWS));
    assign ram_rd_addr   = ADDR_W'(bank_addr(32'(rd_bank_q), 32'(rd_row_q), 32'(rd_col_q),
                                             ROW_LEN, NUM_ROWS));

`ifdef DEINT_TLAST_EN
    logic              rd_last_q;
    logic              rd_last_d;
    logic [DATA_W:0]   buf_head;

    assign rd_last_d = ram_rd_en && rd_at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_last_q <= 1'b0;
        else        rd_last_q <= rd_last_d;
    end

    deint_out_buf2 #(.W(DATA_W + 1)) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (ram_rd_en),
        .in_data   ({rd_last_q, ram_rd_data}),
        .can_issue (can_issue),
        .m_data    (buf_head),
        .m_valid   (m_axis_tvalid),
        .m_ready   (m_axis_tready)
    );

    assign m_axis_tdata = buf_head[DATA_W-1:0];
    assign m_axis_tlast = buf_head[DATA_W];
`else
    deint_out_buf2 #(.W(DATA_W)) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (ram_rd_en),
        .in_data   (ram_rd_data),
        .can_issue (can_issue),
        .m_data    (m_axis_tdata),
        .m_valid   (m_axis_tvalid),
        .m_ready   (m_axis_tready)
    );
`endif

endmodule

// File: tb/tb_deint_pingpong_ctrl.sv
// Bench for deint_pingpong_ctrl: a small 3x2 instance under randomized traffic
// and a default-size instance streaming three banks.
module tb_deint_pingpong_ctrl;
    import deint_pkg::*;

    localparam int RL_A = 3;
    localparam int NR_A = 2;
    localparam int BW_A = RL_A * NR_A;
    localparam int AW_A = $clog2(2 * BW_A);
    localparam int BW_B = BANK_WORDS;
    localparam int AW_B = $clog2(2 * BW_B);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Output word k of a bank is the input word at row k%nr, column k/nr.
    function automatic int perm_src(input int k, input int rl, input int nr);
        return (k % nr) * rl + (k / nr);
    endfunction

    // ---------------- instance A (3 x 2) ----------------
    logic rst_n = 1'b0;
    logic [31:0] s_data_a = '0;
    logic s_valid_a = 1'b0, s_ready_a;
    logic wr_en_a, rd_en_a;
    logic [AW_A-1:0] wr_addr_a, rd_addr_a;
    logic [31:0] wr_data_a, rd_data_a, m_data_a;
    logic m_valid_a, m_ready_a = 1'b0;
    logic [1:0] bank_full_a;
`ifdef DEINT_TLAST_EN
    logic m_last_a, m_last_b;
`endif
    logic [31:0] mem_a [2**AW_A];

    deint_pingpong_ctrl #(.ROW_LEN(RL_A), .NUM_ROWS(NR_A), .DATA_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data_a), .s_axis_tvalid(s_valid_a), .s_axis_tready(s_ready_a),
        .ram_wr_en(wr_en_a), .ram_wr_addr(wr_addr_a), .ram_wr_data(wr_data_a),
        .ram_rd_en(rd_en_a), .ram_rd_addr(rd_addr_a), .ram_rd_data(rd_data_a),
        .m_axis_tdata(m_data_a), .m_axis_tvalid(m_valid_a), .m_axis_tready(m_ready_a),
`ifdef DEINT_TLAST_EN
        .m_axis_tlast(m_last_a),
`endif
        .bank_full(bank_full_a)
    );

    always @(posedge clk) begin
        if (wr_en_a) mem_a[wr_addr_a] <= wr_data_a;
        if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    end

    int rmode = 0;  // 0: ready low, 1: ready high, 2: random
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0:       m_ready_a = 1'b0;
            1:       m_ready_a = 1'b1;
            default: m_ready_a = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard for instance A.
    logic [31:0] in_q[$];
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    int acc_cnt = 0, out_cnt = 0, acc_cyc = 0;
    bit lat_armed = 0, lat_wait = 0, stall_hold = 0;
    logic [31:0] hold_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_hold = 0;
        end else begin
            if (s_valid_a && s_ready_a) begin
                acc_cnt++;
                in_q.push_back(s_data_a);
                if (in_q.size() == BW_A) begin
                    for (int k = 0; k < BW_A; k++) begin
                        exp_q.push_back(in_q[perm_src(k, RL_A, NR_A)]);
                        exp_last_q.push_back(k == BW_A - 1);
                    end
                    in_q.delete();
                    if (lat_armed) begin
                        acc_cyc = cyc + 1;
                        lat_wait = 1;
                        lat_armed = 0;
                    end
                end
            end
            if (stall_hold) begin
                check_eq("stall_valid", m_valid_a, 1'b1);
                check_eq("stall_data", m_data_a, hold_data);
            end
            if (m_valid_a && lat_wait) begin
                check_eq("first_out_latency", cyc - acc_cyc, 2);
                lat_wait = 0;
            end
            if (m_valid_a && m_ready_a) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_expected_avail", 64'(exp_q.size()), 64'd1);
                end else begin
                    check_eq("out_data", m_data_a, exp_q.pop_front());
`ifdef DEINT_TLAST_EN
                    check_eq("out_tlast", m_last_a, exp_last_q.pop_front());
`else
                    void'(exp_last_q.pop_front());
`endif
                end
                out_cnt++;
            end
            stall_hold = m_valid_a && !m_ready_a;
            hold_data  = m_data_a;
        end
    end

    task automatic send_a(input logic [31:0] d);
        int budget = 400;
        s_data_a  = d;
        s_valid_a = 1'b1;
        @(negedge clk);
        while (!s_ready_a && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!s_ready_a) check_eq("send_a_timeout", s_ready_a, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic idle_a(input int n);
        s_valid_a = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain_a();
        int budget = 2000;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_valid_a) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq("drain_remaining", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- instance B (defaults) ----------------
    logic rst_n_b = 1'b0;
    logic [31:0] s_data_b = '0;
    logic s_valid_b = 1'b0, s_ready_b;
    logic wr_en_b, rd_en_b;
    logic [AW_B-1:0] wr_addr_b, rd_addr_b;
    logic [31:0] wr_data_b, rd_data_b, m_data_b;
    logic m_valid_b;
    logic m_ready_b = 1'b1;
    logic [1:0] bank_full_b;
    logic [31:0] mem_b [2**AW_B];

    deint_pingpong_ctrl dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .s_axis_tdata(s_data_b), .s_axis_tvalid(s_valid_b), .s_axis_tready(s_ready_b),
        .ram_wr_en(wr_en_b), .ram_wr_addr(wr_addr_b), .ram_wr_data(wr_data_b),
        .ram_rd_en(rd_en_b), .ram_rd_addr(rd_addr_b), .ram_rd_data(rd_data_b),
        .m_axis_tdata(m_data_b), .m_axis_tvalid(m_valid_b), .m_axis_tready(m_ready_b),
`ifdef DEINT_TLAST_EN
        .m_axis_tlast(m_last_b),
`endif
        .bank_full(bank_full_b)
    );

    always @(posedge clk) begin
        if (wr_en_b) mem_b[wr_addr_b] <= wr_data_b;
        if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
    end

    int out_b_cnt = 0, viol_b = 0;
    bit b_started = 0;
    logic [31:0] cap_b [8];

    always @(negedge clk) begin
        if (rst_n_b) begin
            if (s_ready_b) b_started = 1;
            if (b_started && !s_ready_b && bank_full_b != 2'b11) viol_b++;
            if (m_valid_b && m_ready_b) begin
                check_eq("b_out_data", m_data_b,
                         32'((out_b_cnt / BW_B) * BW_B + perm_src(out_b_cnt % BW_B, DEF_ROW_LEN, DEF_NUM_ROWS)));
`ifdef DEINT_TLAST_EN
                check_eq("b_out_tlast", m_last_b, (out_b_cnt % BW_B) == BW_B - 1);
`endif
                if (out_b_cnt < 6) cap_b[out_b_cnt] = m_data_b;
                if (out_b_cnt == BW_B)     cap_b[6] = m_data_b;
                if (out_b_cnt == BW_B + 1) cap_b[7] = m_data_b;
                out_b_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        #2;
        check_eq("rst_s_ready", s_ready_a, 1'b0);
        check_eq("rst_m_valid", m_valid_a, 1'b0);
        check_eq("rst_m_data", m_data_a, 32'd0);
        check_eq("rst_rd_en", rd_en_a, 1'b0);
        check_eq("rst_bank_full", bank_full_a, 2'b00);
        #10 rst_n = 1'b1;          // released between edges
        @(negedge clk);
        check_eq("ready_after_reset", s_ready_a, 1'b1);
        @(posedge clk); #1;

        // Back-to-back 0..5 with ready high, plus first-output latency.
        rmode = 1;
        idle_a(2);
        lat_armed = 1;
        for (int i = 0; i < BW_A; i++) send_a(32'(i));
        idle_a(0);
        wait_drain_a();

        // Same words with a random ready pattern.
        rmode = 2;
        for (int i = 0; i < BW_A; i++) send_a(32'(i));
        idle_a(0);
        wait_drain_a();

        // Random data, random gaps, random ready over several banks.
        for (int i = 0; i < 5 * BW_A; i++) begin
            send_a($urandom);
            idle_a($urandom_range(0, 2));
        end
        wait_drain_a();

        // Both banks full with ready low: writer must stall.
        rmode = 0;
        idle_a(2);
        base = out_cnt;
        for (int i = 0; i < 2 * BW_A; i++) send_a(32'(100 + i));
        s_data_a  = 32'd999;
        s_valid_a = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        @(negedge clk);
        check_eq("noroom_bank_full", bank_full_a, 2'b11);
        check_eq("noroom_s_ready", s_ready_a, 1'b0);
        check_eq("noroom_no_accept", in_q.size(), 0);
        @(posedge clk); #1;
        s_valid_a = 1'b0;
        rmode = 1;
        wait_drain_a();
        check_eq("noroom_out_count", out_cnt - base, 2 * BW_A);
        @(negedge clk);
        check_eq("noroom_ready_back", s_ready_a, 1'b1);
        @(posedge clk); #1;

        // Reset in the middle of draining a bank.
        base = out_cnt;
        for (int i = 0; i < BW_A; i++) send_a(32'(20 + i));
        idle_a(0);
        begin
            int budget = 200;
            @(negedge clk);
            while (out_cnt < base + 3 && budget > 0) begin @(negedge clk); budget--; end
            check_eq("reset_point_reached", out_cnt >= base + 3, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_m_valid", m_valid_a, 1'b0);
        check_eq("midrst_bank_full", bank_full_a, 2'b00);
        check_eq("midrst_s_ready", s_ready_a, 1'b0);
        exp_q.delete();
        exp_last_q.delete();
        in_q.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < BW_A; i++) send_a(32'(10 + i));
        idle_a(0);
        wait_drain_a();

        // Default-size instance: three banks of 0..779 streamed continuously.
        rst_n_b = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3 * BW_B; i++) begin
            int budget = 2000;
            s_data_b  = 32'(i);
            s_valid_b = 1'b1;
            @(negedge clk);
            while (!s_ready_b && budget > 0) begin @(negedge clk); budget--; end
            if (!s_ready_b) check_eq("send_b_timeout", s_ready_b, 1'b1);
            @(posedge clk); #1;
        end
        s_valid_b = 1'b0;
        begin
            int budget = 3000;
            @(negedge clk);
            while (out_b_cnt < 3 * BW_B && budget > 0) begin @(negedge clk); budget--; end
        end
        check_eq("b_out_count", out_b_cnt, 3 * BW_B);
        check_eq("b_ready_only_when_full", viol_b, 0);
        check_eq("b_bank0_w0", cap_b[0], 32'd0);
        check_eq("b_bank0_w1", cap_b[1], 32'd65);
        check_eq("b_bank0_w2", cap_b[2], 32'd130);
        check_eq("b_bank0_w3", cap_b[3], 32'd195);
        check_eq("b_bank0_w4", cap_b[4], 32'd1);
        check_eq("b_bank0_w5", cap_b[5], 32'd66);
        check_eq("b_bank1_w0", cap_b[6], 32'd260);
        check_eq("b_bank1_w1", cap_b[7], 32'd325);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
